// File: rtl/parallel_to_serial.sv
// parallel_to_serial: accepts a WIDTH-bit word when idle and shifts it out
// LSB first as WIDTH consecutive single-bit beats. Words offered while busy
// are dropped; the producer is expected to watch o_busy.
module parallel_to_serial #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_parallel_valid,
  input  logic [WIDTH-1:0] i_parallel_data,
  output logic             o_busy,
  output logic             o_serial_valid,
  output logic             o_serial_data
);

  logic [WIDTH-1:0] r_sr;    // word being shifted out, bit 0 is the current beat
  logic [CW-1:0]    r_cnt;   // beats still to present, 0 means idle
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_idle;
  logic             w_accept;

  assign w_idle   = (r_cnt == '0);
  // parallel_data is only looked at on an accept, so X on an idle bus never
  // reaches the shift register.
  assign w_accept = w_idle & i_parallel_valid;

  // Next-state: load on accept, shift/count down while busy, hold when idle.
  always_comb begin
    w_sr_nxt  = r_sr;
    w_cnt_nxt = r_cnt;
    if (w_accept) begin
      w_sr_nxt  = i_parallel_data;
      w_cnt_nxt = CW'(WIDTH);
    end else if (!w_idle) begin
      w_sr_nxt  = {1'b0, r_sr[WIDTH-1:1]};
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  // State registers; reset drops any word in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= w_sr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Outputs decode registered state only; no path from the inputs.
  assign o_busy         = ~w_idle;
  assign o_serial_valid = ~w_idle;
  assign o_serial_data  = ~w_idle & r_sr[0];

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial: a reference model turns each
// accepted word into LSB-first bits in a queue; a monitor pops on every beat.
module tb_parallel_to_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pv;
  logic [W-1:0] pd;
  logic         o_busy, o_sv, o_sd;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int words    = 0;
  int n_edge   = 0;
  int acc_edge = -100;
  bit exp_q[$];

  parallel_to_serial #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_parallel_valid(pv), .i_parallel_data(pd),
    .o_busy(o_busy), .o_serial_valid(o_sv), .o_serial_data(o_sd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word is taken when it is offered and at least W+1
  // edges have passed since the previous accepted word; reset discards all.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        acc_edge = -100;
      end else begin
        n_edge++;
        if (pv && (n_edge - acc_edge) > W) begin
          acc_edge = n_edge;
          words++;
          for (int i = 0; i < W; i++) exp_q.push_back(pd[i]);
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops one expected bit per beat.
  initial begin
    bit b;
    bit exp_b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_valid", int'(o_sv), 0);
        chk("rst_data", int'(o_sd), 0);
      end else begin
        exp_b = ((n_edge - acc_edge) >= 0) && ((n_edge - acc_edge) < W);
        chk("busy", int'(o_busy), int'(exp_b));
        chk("serial_valid", int'(o_sv), int'(exp_b));
        if (o_sv) begin
          beats++;
          if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            b = exp_q.pop_front();
            chk("serial_data", int'(o_sd), int'(b));
          end
        end else begin
          chk("idle_data", int'(o_sd), 0);
        end
      end
    end
  end

  // Called on a falling edge: wait for idle, offer the word for one cycle.
  task automatic send(input logic [W-1:0] d);
    int t = 0;
    while (o_busy && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("busy_timeout", 1, 0);
    pv = 1'b1;
    pd = d;
    @(negedge clk);
    pv = 1'b0;
    pd = 'x;
  endtask

  task automatic drain();
    int t = 0;
    while (o_busy && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int b0, w0;
    logic [W-1:0] d;
    rst_n = 1'b0;
    pv    = 1'b1;
    pd    = 8'hA5;
    repeat (4) @(negedge clk);
    pv = 1'b0;
    pd = 'x;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_beats", beats, 0);

    // Single word 0xB4
    b0 = beats; w0 = words;
    send(8'hB4);
    drain();
    chk("b4_beats", beats - b0, 8);
    chk("b4_words", words - w0, 1);

    // Alternating 0xFF / 0x00, back to back as soon as busy clears
    b0 = beats; w0 = words;
    for (int i = 0; i < 11; i++) send((i % 2 == 0) ? 8'hFF : 8'h00);
    drain();
    chk("alt_beats", beats - b0, 88);
    chk("alt_words", words - w0, 11);

    // Offers while busy are dropped
    b0 = beats; w0 = words;
    send(8'h0F);
    pv = 1'b1;
    pd = 8'hAA;
    repeat (4) @(negedge clk);
    pv = 1'b0;
    pd = 'x;
    drain();
    chk("drop_beats", beats - b0, 8);
    chk("drop_words", words - w0, 1);

    // Reset after three beats of 0x55
    b0 = beats;
    send(8'h55);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_valid", int'(o_sv), 0);
    chk("midrst_data", int'(o_sd), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_beats", beats - b0, 3);
    chk("midrst_queue", exp_q.size(), 0);

    // Random soak with gaps and junk offered while busy
    b0 = beats; w0 = words;
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = W'($urandom);
      send(d);
      if ($urandom_range(0, 1) == 1) begin
        pv = 1'b1;
        pd = W'($urandom);
        @(negedge clk);
        pv = 1'b0;
        pd = 'x;
      end
    end
    drain();
    chk("soak_beats", beats - b0, 800);
    chk("soak_words", words - w0, 100);
    chk("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
Converts a parallel word into a serial bitstream, LSB first. Each accepted word produces exactly `width` consecutive serial output beats, each with serial_valid high. `busy` is the backpressure signal to the upstream producer: words offered while it is high are dropped. The block sits between a word-oriented producer and a single-bit serial consumer.

Parameters:
- width, 8, number of bits per parallel word; legal range 2 or more.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- parallel_valid, input, 1, parallel_data holds a word this cycle.
- parallel_data, input, width, word to serialize; bit 0 is sent first.
- busy, output, 1, high while a word is being shifted out; parallel_valid is ignored while high.
- serial_valid, output, 1, serial_data is a valid beat this cycle.
- serial_data, output, 1, current serial bit.

Behaviour:
- Reset: rst_n low asynchronously clears the shift register, the bit counter, busy, serial_valid and serial_data, all to 0.
- Reset mid-word: the word in flight is discarded and no further beats are emitted. After rst_n rises, the block is idle.
- Internal state:
  - shift register sr[width-1:0].
  - counter cnt, width $clog2(width+1), counts remaining beats.
- Idle state is cnt == 0.
- Accept condition: parallel_valid=1 and cnt==0 at a rising edge. On accept:
  - sr <= parallel_data.
  - cnt <= width.
- Busy state is cnt != 0. On each rising edge:
  - sr <= sr >> 1, zero-filled.
  - cnt <= cnt - 1.
- Outputs, all driven from registers with no combinational path from inputs:
  - busy = (cnt != 0).
  - serial_valid = (cnt != 0).
  - serial_data = sr[0] while busy, 0 when idle.
- Latency: word accepted at edge E0. Bit i is presented during the cycle after edge E0+i, for i = 0..width-1. serial_valid is high for exactly `width` consecutive cycles.
- busy is visible right after the accepting edge, so a producer sampling it shortly after the edge sees 1.
- busy falls after edge E0+width. The earliest next accept is edge E0+width+1, giving one idle cycle between words. No back-to-back acceptance.
- parallel_valid while busy: ignored. The word is lost, and the in-flight word is unaffected. The upstream must watch busy.
- parallel_data is don't-care when parallel_valid=0; X on it must not propagate.
- Counting invariant: total serial_valid beats = width × number of accepted words.

Test Plan:
- Reset: hold rst_n=0 with parallel_valid=1 -> busy=0, serial_valid=0 and serial_data=0 throughout; on release, idle with no output.
- Single word 8'hB4 (width=8): accepted at E0 -> serial_valid high for 8 cycles. serial_data sequence 0,0,1,0,1,1,0,1. busy drops after E8.
- Alternating words 8'hFF, 8'h00, 8'hFF, …, each issued as soon as busy=0, 11 words -> 88 beats, all 1s then all 0s per word, in order.
- Valid while busy: word 8'h0F accepted, then 8'hAA offered on cycles 2–5 -> output is only 1,1,1,1,0,0,0,0. The extra words are dropped and the beat count is 8.
- Reset mid-word: accept 8'h55, then pull rst_n low after 3 beats -> outputs clear immediately. No remaining beats appear after release.
- Random soak: 100 words with random parallel_valid gaps and random data -> serial stream equals the LSB-first concatenation of accepted words; beat count = 800.
